// File: rtl/dmem_responder.sv
// Data-memory responder for the memory stage. It accepts one word request at a
// time, spends LATENCY cycles on the access, and then returns a one-cycle
// response carrying load data or a misalignment error.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [3:0]       waitCnt;
  logic             latWe;
  logic [IDX_W+1:0] latAddr;
  logic [31:0]      latWdata;
  logic [31:0]      mem [DEPTH_WORDS];

  logic             accept;
  logic             enterResp;
  logic             opWe;
  logic [IDX_W+1:0] opAddr;
  logic [31:0]      opWdata;
  logic [IDX_W-1:0] opIdx;
  logic             opMis;

  // Upper address bits do not take part in indexing; addresses wrap.
  logic unusedAddrHi;
  assign unusedAddrHi = ^req_addr[31:IDX_W+2];

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && (state == IDLE);

  // With a single-cycle latency the access completes on the accept edge, so
  // the operation comes straight from the request inputs instead of the latch.
  always_comb begin
    enterResp = 1'b0;
    opWe      = latWe;
    opAddr    = latAddr;
    opWdata   = latWdata;
    if (LATENCY == 1) begin
      enterResp = accept;
      opWe      = req_we;
      opAddr    = req_addr[IDX_W+1:0];
      opWdata   = req_wdata;
    end else begin
      enterResp = (state == WAIT) && (waitCnt == 4'd1);
    end
  end

  assign opIdx = opAddr[IDX_W+1:2];
  assign opMis = (opAddr[1:0] != 2'b00);

  // Control FSM: IDLE -> (WAIT countdown) -> RESP -> IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      waitCnt <= 4'd0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          if (LATENCY == 1) state <= RESP;
          else begin
            state   <= WAIT;
            waitCnt <= 4'(LATENCY - 1);
          end
        end
        WAIT: if (waitCnt == 4'd1) state <= RESP;
              else waitCnt <= waitCnt - 4'd1;
        default: state <= IDLE;
      endcase
    end
  end

  // Capture the request on acceptance; fields may change freely afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      latWe    <= 1'b0;
      latAddr  <= '0;
      latWdata <= '0;
    end else if (accept) begin
      latWe    <= req_we;
      latAddr  <= req_addr[IDX_W+1:0];
      latWdata <= req_wdata;
    end
  end

  // Storage is never cleared; the write is gated by reset so a store that is
  // still pending when reset hits is dropped.
  always_ff @(posedge clk) begin
    if (reset && enterResp && opWe && !opMis) mem[opIdx] <= opWdata;
  end

  // Response data/error: loaded on entry to RESP, held between responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (enterResp) begin
      resp_err   <= opMis;
      resp_rdata <= (opWe || opMis) ? 32'd0 : mem[opIdx];
    end
  end
endmodule
